// File: rtl/alu_pkg.sv
// Shared types and operation-decoding helpers for the iterative RV M-extension unit.
package alu_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } md_state_e;

   function automatic logic is_div(input md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
   endfunction

   function automatic logic is_rem(input md_op_e op);
      return (op == MD_REM) || (op == MD_REMU);
   endfunction

   function automatic logic is_signed_a(input md_op_e op);
      return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
   endfunction

   function automatic logic is_signed_b(input md_op_e op);
      return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration step: shift-add multiply or restoring-divide,
// sharing a {hi, lo} accumulator pair with the caller.
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            is_div_op,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] operand,
   output logic [XLEN-1:0] hi_nxt,
   output logic [XLEN-1:0] lo_nxt
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem_sh;
   logic [XLEN-1:0] diff;
   logic            ge;

   // The remainder always stays below the divisor, so the difference fits XLEN bits.
   always_comb begin
      sum    = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
      rem_sh = {hi, lo[XLEN-1]};
      ge     = rem_sh >= {1'b0, operand};
      diff   = rem_sh[XLEN-1:0] - operand;
      if (is_div_op) begin
         hi_nxt = ge ? diff : rem_sh[XLEN-1:0];
         lo_nxt = {lo[XLEN-2:0], ge};
      end else begin
         hi_nxt = sum[XLEN:1];
         lo_nxt = {sum[0], lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV M-extension unit (MUL*/DIV*/REM*) with valid/ready on both sides.
// Operates on magnitudes for XLEN cycles, then applies sign correction in FIX.
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_Ra,
   input  logic [XLEN-1:0] i_Rb,
   input  logic            i_kill,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_Rc,
   output logic            o_Z
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e       state, next_state;
   md_op_e          op_in, op_q;
   logic [XLEN-1:0] acc_hi, acc_lo, b_mag, hi_nxt, lo_nxt;
   logic [XLEN-1:0] a_in_mag, b_in_mag, special_res, fixed_res;
   logic [2*XLEN-1:0] prod, prod_s;
   logic            neg_prod, neg_rem;
   logic            sign_a_in, sign_b_in;
   logic            accept, div_zero, overflow, special;
   logic [CNT_W-1:0] cnt;

   assign op_in = md_op_e'(i_op);
   assign o_Z   = (o_Rc == '0);

   always_comb begin
      sign_a_in   = is_signed_a(op_in) && i_Ra[XLEN-1];
      sign_b_in   = is_signed_b(op_in) && i_Rb[XLEN-1];
      a_in_mag    = sign_a_in ? -i_Ra : i_Ra;
      b_in_mag    = sign_b_in ? -i_Rb : i_Rb;
      accept      = i_valid && o_ready && !i_kill;
      div_zero    = is_div(op_in) && (i_Rb == '0);
      overflow    = ((op_in == MD_DIV) || (op_in == MD_REM)) && (i_Ra == MIN_VAL) && (i_Rb == '1);
      special     = div_zero || overflow;
      special_res = '0;
      if (div_zero)
         special_res = is_rem(op_in) ? i_Ra : '1;
      else
         special_res = is_rem(op_in) ? '0 : MIN_VAL;
   end

   muldiv_iter #(.XLEN(XLEN)) u_iter (
      .is_div_op (is_div(op_q)),
      .hi        (acc_hi),
      .lo        (acc_lo),
      .operand   (b_mag),
      .hi_nxt    (hi_nxt),
      .lo_nxt    (lo_nxt)
   );

   // Sign correction: quotient follows the product sign rule, remainder the dividend.
   always_comb begin
      prod   = {acc_hi, acc_lo};
      prod_s = neg_prod ? -prod : prod;
      case (op_q)
         MD_MUL:                      fixed_res = prod_s[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: fixed_res = prod_s[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:             fixed_res = neg_prod ? -acc_lo : acc_lo;
         default:                     fixed_res = neg_rem ? -acc_hi : acc_hi;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (i_kill) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) next_state = special ? DONE : CALC;
            CALC:    if (cnt == '0) next_state = FIX;
            FIX:     next_state = DONE;
            DONE:    if (o_valid && i_ready) next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      o_ready = (state == IDLE);
   end

   // o_valid is registered, so it rises the edge after DONE is entered.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         o_valid  <= 1'b0;
         o_Rc     <= '0;
         cnt      <= '0;
         op_q     <= MD_MUL;
         acc_hi   <= '0;
         acc_lo   <= '0;
         b_mag    <= '0;
         neg_prod <= 1'b0;
         neg_rem  <= 1'b0;
      end else begin
         o_valid <= (state == DONE) && !i_kill && !(o_valid && i_ready);
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q     <= op_in;
                  acc_hi   <= '0;
                  acc_lo   <= a_in_mag;
                  b_mag    <= b_in_mag;
                  neg_prod <= sign_a_in ^ sign_b_in;
                  neg_rem  <= sign_a_in;
                  cnt      <= CNT_W'(XLEN-1);
                  if (special)
                     o_Rc <= special_res;
               end
            end
            CALC: begin
               acc_hi <= hi_nxt;
               acc_lo <= lo_nxt;
               if (cnt != '0)
                  cnt <= cnt - CNT_W'(1);
            end
            FIX: begin
               if (!i_kill)
                  o_Rc <= fixed_res;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed spec cases, randomized ops against
// a 64-bit arithmetic reference model, handshake stall, back-to-back, kill and reset.
module tb_alu_muldiv;

   logic        i_clk;
   logic        i_rstn;
   logic        i_valid;
   logic        o_ready;
   logic [2:0]  i_op;
   logic [31:0] i_Ra;
   logic [31:0] i_Rb;
   logic        i_kill;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_Rc;
   logic        o_Z;

   int n_compared;
   int n_mismatched;

   alu_muldiv #(.XLEN(32)) dut (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_op    (i_op),
      .i_Ra    (i_Ra),
      .i_Rb    (i_Rb),
      .i_kill  (i_kill),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_Rc    (o_Rc),
      .o_Z     (o_Z)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Reference: plain 64-bit arithmetic with the RISC-V special-case rules.
   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, sp;
      logic [63:0] ua, ub, up;
      logic [31:0] res;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      sp  = '0;
      up  = '0;
      res = '0;
      case (op)
         3'd0: begin sp = sa * sb; res = sp[31:0]; end
         3'd1: begin sp = sa * sb; res = sp[63:32]; end
         3'd2: begin sp = sa * $signed(ub); res = sp[63:32]; end
         3'd3: begin up = ua * ub; res = up[63:32]; end
         3'd4: begin
            if (b == 32'd0) res = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h8000_0000;
            else begin sp = sa / sb; res = sp[31:0]; end
         end
         3'd5: begin
            if (b == 32'd0) res = 32'hFFFF_FFFF;
            else begin up = ua / ub; res = up[31:0]; end
         end
         3'd6: begin
            if (b == 32'd0) res = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'd0;
            else begin sp = sa % sb; res = sp[31:0]; end
         end
         default: begin
            if (b == 32'd0) res = a;
            else begin up = ua % ub; res = up[31:0]; end
         end
      endcase
      return res;
   endfunction

   function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && b == 32'd0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Callers are positioned #1 after a clock edge with the unit idle.
   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      i_op    = op;
      i_Ra    = a;
      i_Rb    = b;
      i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!o_valid && lat < 100) begin
         @(posedge i_clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z, output int lat);
      start_op(op, a, b);
      wait_result(lat);
      res = o_Rc;
      z   = o_Z;
      @(posedge i_clk); #1;
   endtask

   task automatic test_reset();
      i_rstn  = 1'b0;
      i_valid = 1'b0;
      i_kill  = 1'b0;
      i_ready = 1'b1;
      i_op    = 3'd0;
      i_Ra    = 32'd0;
      i_Rb    = 32'd0;
      repeat (2) @(posedge i_clk);
      #1;
      n_compared++;
      if (o_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid got %b want 0", o_valid); end
      n_compared++;
      if (o_Rc !== 32'd0) begin n_mismatched++; $display("[TB] FAIL reset_rc got %h want 0", o_Rc); end
      n_compared++;
      if (o_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_ready got %b want 1", o_ready); end
      n_compared++;
      if (o_Z !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_z got %b want 1", o_Z); end
      i_rstn = 1'b1;
      @(posedge i_clk); #1;
   endtask

   task automatic test_directed();
      logic [2:0]  d_op  [15] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                  3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd5};
      logic [31:0] d_a   [15] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                                  32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                  32'd6, 32'd1234, 32'd5, 32'h8000_0000, 32'h8000_0000,
                                  32'd5, 32'h8000_0000};
      logic [31:0] d_b   [15] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                                  32'd2, 32'd2, 32'd7, 32'd7,
                                  32'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'd0, 32'hFFFF_FFFF};
      logic [31:0] d_exp [15] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                  32'd0, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                                  32'hFFFF_FFFF, 32'd0};
      logic [31:0] res;
      logic        z;
      int          lat;
      for (int i = 0; i < 15; i++) begin
         run_op(d_op[i], d_a[i], d_b[i], res, z, lat);
         n_compared++;
         if (res !== d_exp[i]) begin
            n_mismatched++;
            $display("[TB] FAIL directed_rc[%0d] op=%0d got %h want %h", i, d_op[i], res, d_exp[i]);
         end
         n_compared++;
         if (z !== (d_exp[i] == 32'd0)) begin
            n_mismatched++;
            $display("[TB] FAIL directed_z[%0d] got %b want %b", i, z, (d_exp[i] == 32'd0));
         end
         n_compared++;
         if (lat != exp_latency(d_op[i], d_a[i], d_b[i])) begin
            n_mismatched++;
            $display("[TB] FAIL directed_latency[%0d] got %0d want %0d", i, lat, exp_latency(d_op[i], d_a[i], d_b[i]));
         end
      end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b, res, exp;
      logic        z;
      int          lat, sel;
      for (int i = 0; i < 40; i++) begin
         op  = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) b = 32'($urandom_range(1, 15));
         exp = ref_model(op, a, b);
         run_op(op, a, b, res, z, lat);
         n_compared++;
         if (res !== exp || z !== (exp == 32'd0)) begin
            n_mismatched++;
            $display("[TB] FAIL random_rc[%0d] op=%0d a=%h b=%h got %h/z%b want %h", i, op, a, b, res, z, exp);
         end
         n_compared++;
         if (lat != exp_latency(op, a, b)) begin
            n_mismatched++;
            $display("[TB] FAIL random_latency[%0d] got %0d want %0d", i, lat, exp_latency(op, a, b));
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      i_ready = 1'b0;
      start_op(3'd5, 32'd100, 32'd7);
      wait_result(lat);
      n_compared++;
      if (lat != 34 || o_Rc !== 32'd14) begin
         n_mismatched++;
         $display("[TB] FAIL stall_first got lat %0d rc %h want lat 34 rc 0000000e", lat, o_Rc);
      end
      i_op    = 3'd6;
      i_Ra    = 32'hFFFF_FFF9;
      i_Rb    = 32'd2;
      i_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge i_clk); #1;
         n_compared++;
         if (o_valid !== 1'b1 || o_Rc !== 32'd14 || o_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL stall_hold[%0d] got valid %b rc %h ready %b want 1 0000000e 0", c, o_valid, o_Rc, o_ready);
         end
      end
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      n_compared++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL handoff got valid %b ready %b want 0 1", o_valid, o_ready);
      end
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      n_compared++;
      if (o_ready !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL b2b_accept got ready %b want 0", o_ready);
      end
      wait_result(lat);
      n_compared++;
      if (lat != 34 || o_Rc !== ref_model(3'd6, 32'hFFFF_FFF9, 32'd2)) begin
         n_mismatched++;
         $display("[TB] FAIL b2b_second got lat %0d rc %h want lat 34 rc ffffffff", lat, o_Rc);
      end
      @(posedge i_clk); #1;
   endtask

   task automatic test_kill();
      logic [31:0] res;
      logic        z;
      int          lat, seen;
      start_op(3'd0, 32'd12345, 32'd678);
      repeat (9) begin @(posedge i_clk); #1; end
      i_kill = 1'b1;
      @(posedge i_clk); #1;
      i_kill = 1'b0;
      n_compared++;
      if (o_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL kill_ready got %b want 1", o_ready); end
      seen = 0;
      repeat (40) begin @(posedge i_clk); #1; if (o_valid) seen++; end
      n_compared++;
      if (seen != 0) begin n_mismatched++; $display("[TB] FAIL kill_no_valid got %0d valid cycles want 0", seen); end

      start_op(3'd4, 32'd1000, 32'd3);
      repeat (4) begin @(posedge i_clk); #1; end
      i_rstn = 1'b0;
      @(posedge i_clk); #1;
      i_rstn = 1'b1;
      n_compared++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL midreset_state got ready %b valid %b want 1 0", o_ready, o_valid);
      end
      seen = 0;
      repeat (40) begin @(posedge i_clk); #1; if (o_valid) seen++; end
      n_compared++;
      if (seen != 0) begin n_mismatched++; $display("[TB] FAIL midreset_no_valid got %0d valid cycles want 0", seen); end

      i_op    = 3'd5;
      i_Ra    = 32'd8;
      i_Rb    = 32'd0;
      i_valid = 1'b1;
      i_kill  = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_kill  = 1'b0;
      seen = 0;
      repeat (5) begin @(posedge i_clk); #1; if (o_valid || !o_ready) seen++; end
      n_compared++;
      if (seen != 0) begin n_mismatched++; $display("[TB] FAIL kill_idle_accept got %0d busy cycles want 0", seen); end

      run_op(3'd5, 32'd9, 32'd3, res, z, lat);
      n_compared++;
      if (res !== 32'd3 || lat != 34) begin
         n_mismatched++;
         $display("[TB] FAIL after_kill_divu got rc %h lat %0d want 00000003 lat 34", res, lat);
      end
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_kill();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
